// File: rtl/booth_seq_mult_ctrl.sv
// Iterative radix-2 Booth multiplier. One (WIDTH+1)-bit add/sub plus arithmetic shift
// per cycle over WIDTH+1 cycles, with valid/ready handshakes on both sides.
module booth_seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [WIDTH:0]   r_a;
    logic signed [WIDTH:0]   r_q;
    logic signed [WIDTH:0]   r_m;
    logic                    r_q1;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_accept;
    logic                    w_last;
    logic signed [WIDTH:0]   w_sum;

    // One extra MSB lets the unsigned mode share the signed Booth datapath.
    function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    function automatic logic signed [WIDTH:0] booth_sum(input logic signed [WIDTH:0] a,
                                                        input logic signed [WIDTH:0] m,
                                                        input logic q0,
                                                        input logic q1);
        case ({q0, q1})
            2'b01:   return a + m;
            2'b10:   return a - m;
            default: return a;
        endcase
    endfunction

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_cnt == CNT_W'(WIDTH));
    assign w_sum     = booth_sum(r_a, r_m, r_q[0], r_q1);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign product   = {r_a[WIDTH-2:0], r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Accept loads operands; each RUN cycle does add/sub then arithmetic shift of {S,Q,q_1}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_m   <= ext(multiplicand, in_signed);
            r_q   <= ext(multiplier, in_signed);
            r_a   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH:1]};
            r_q1  <= r_q[0];
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
